// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, in-order memory requests and a 2-entry {pc, word} queue to decode.
// Defining IF_PERF_CNT_EN adds the perf_fetch_cnt / perf_flush_cnt event counters.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_request,
  input  logic        branch_flag,
  input  logic [31:0] branch_addr,
  output logic        rom_en,
  output logic [31:0] rom_addr,
  input  logic        rom_ready,
  input  logic        rom_rvalid,
  input  logic [31:0] rom_rdata,
  output logic        inst_valid,
  output logic [31:0] addr,
  output logic [31:0] inst
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [1:0]  outstanding_q, outstanding_d;
  logic [1:0]  drop_q, drop_d;
  logic [31:0] tag_q [2];
  logic        tag_wr_q, tag_rd_q;
  logic [31:0] fifo_pc_q [2];
  logic [31:0] fifo_inst_q [2];
  logic        fifo_wr_q, fifo_wr_d;
  logic        fifo_rd_q, fifo_rd_d;
  logic [1:0]  fifo_cnt_q, fifo_cnt_d;
  logic        pop, accept, resp, deliver;
  logic [2:0]  credit_used;

  always_comb begin
    inst_valid  = rst && (fifo_cnt_q != 2'd0);
    addr        = inst_valid ? fifo_pc_q[fifo_rd_q] : 32'h0;
    inst        = inst_valid ? fifo_inst_q[fifo_rd_q] : 32'h0;
    // On a branch cycle an unstalled head is still taken as the delay slot.
    pop         = inst_valid && !stall_request;
    credit_used = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q} - {2'b00, pop};
    rom_en      = rst && !branch_flag && (credit_used < 3'd2);
    rom_addr    = rst ? pc_q : RESET_PC;
    accept      = rom_en && rom_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    resp        = rst && rom_rvalid && (outstanding_q != 2'd0);
    deliver     = resp && (drop_q == 2'd0) && !branch_flag;
  end

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + {1'b0, accept} - {1'b0, resp};
    drop_d        = drop_q;
    fifo_wr_d     = fifo_wr_q;
    fifo_rd_d     = fifo_rd_q;
    fifo_cnt_d    = fifo_cnt_q + {1'b0, deliver} - {1'b0, pop};
    if (accept) pc_d = pc_q + 32'd4;
    if (resp && (drop_q != 2'd0)) drop_d = drop_q - 2'd1;
    if (deliver) fifo_wr_d = ~fifo_wr_q;
    if (pop) fifo_rd_d = ~fifo_rd_q;
    if (branch_flag) begin
      pc_d       = branch_addr & 32'hFFFF_FFFC;
      drop_d     = outstanding_q - {1'b0, resp};
      fifo_cnt_d = 2'd0;
      fifo_wr_d  = 1'b0;
      fifo_rd_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= 2'd0;
      drop_q        <= 2'd0;
      tag_wr_q      <= 1'b0;
      tag_rd_q      <= 1'b0;
      fifo_wr_q     <= 1'b0;
      fifo_rd_q     <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      tag_wr_q      <= tag_wr_q ^ accept;
      tag_rd_q      <= tag_rd_q ^ resp;
      fifo_wr_q     <= fifo_wr_d;
      fifo_rd_q     <= fifo_rd_d;
      fifo_cnt_q    <= fifo_cnt_d;
    end
  end

  // Payload storage needs no reset: occupancy lives in the pointers and counts.
  always_ff @(posedge clk) begin
    if (accept) tag_q[tag_wr_q] <= pc_q;
    if (deliver) begin
      fifo_pc_q[fifo_wr_q]   <= tag_q[tag_rd_q];
      fifo_inst_q[fifo_wr_q] <= rom_rdata;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetch_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + {31'd0, pop};
      perf_flush_cnt <= perf_flush_cnt + {31'd0, branch_flag};
    end
  end
`endif

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage feeding the decode stage: holds the PC, issues in-order reads to instruction memory over a request/response handshake and buffers returned words in a 2-entry queue. Presents `{addr, inst}` to decode and honours decode's `stall_request`, `branch_flag` and `branch_addr`. Sits between instruction ROM/cache and the IF/ID boundary.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: first fetch address after reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `stall_request`  in  1  from decode; head instruction not consumed this cycle.
- `branch_flag`  in  1  from decode; one-cycle redirect pulse.
- `branch_addr`  in  32  redirect target; bits [1:0] ignored (treated as 0).
- `rom_en`  out  1  fetch request valid.
- `rom_addr`  out  32  fetch address, word aligned.
- `rom_ready`  in  1  memory accepts the request this cycle.
- `rom_rvalid`  in  1  response valid; responses return in request order, at least 1 cycle after acceptance.
- `rom_rdata`  in  32  instruction word.
- `inst_valid`  out  1  `addr`/`inst` hold a real instruction.
- `addr`  out  32  PC of presented instruction (0 when empty).
- `inst`  out  32  presented instruction (32'h0 = NOP when empty).

## Operation
- State: `pc`, `outstanding` (0..2), `drop` (0..2), 2-entry address-tag queue of issued PCs, 2-entry instruction FIFO of `{pc, word}`.
- Pop: `pop = inst_valid && !stall_request && !branch_flag`, or `inst_valid && !stall_request` on the branch cycle (the head is taken as the delay-slot instruction).
- Credit: `rom_en = rst && !branch_flag && (outstanding + fifo_count - pop) < 2`; `rom_addr = pc`.
- Accept (`rom_en && rom_ready`): push `pc` onto the tag queue; `pc <= pc + 4`; `outstanding++`.
- Response (`rom_rvalid`): pop the tag queue; `outstanding--`. If `drop > 0`, discard and `drop--`. Otherwise push `{tag, rom_rdata}` into the FIFO.
- Outputs show the FIFO head combinationally. When empty: `inst_valid=0`, `addr=0`, `inst=0`.
- Branch cycle:
  - Clear the FIFO (after optional head pop).
  - `drop <= outstanding` minus any response arriving this cycle; that response is itself discarded.
  - `pc <= {branch_addr[31:2], 2'b00}`.
  - No request is issued.
- `branch_flag` overrides `stall_request`.
- Simultaneous push and pop is legal at any occupancy. Credits guarantee the FIFO never overflows, so `rom_rvalid` is never backpressured.
- `rom_rvalid` with `outstanding == 0` is a protocol error: the response is ignored and no state changes.
- PC wrap-around: 32'hFFFF_FFFC + 4 wraps to 0; no special handling.

## Timing
- Reset (`rst==0` at an edge): `pc=RESET_PC`; `outstanding`, `drop`, `fifo_count` = 0. While `rst==0`, `rom_en=0`, `rom_addr=RESET_PC`, `inst_valid=0`, `addr=0`, `inst=0`.
- Reset mid-operation discards all queued and in-flight state. Responses to pre-reset requests must not be delivered; the memory is reset on the same `rst`.
- First request: the cycle after `rst` rises, at `RESET_PC`.
- Latency: request accepted at T with a 1-cycle memory gives `rom_rvalid` at T+1 and `inst_valid` at T+2.
- Throughput: 1 instruction/cycle with a 1-cycle memory and no stalls.
- Redirect: branch at cycle B; the request for the target is issued at B+1; the target is presented no earlier than B+3.

## Configuration
- `IF_PERF_CNT_EN`: when defined, adds outputs `perf_fetch_cnt` (32, delivered instructions, i.e. pops) and `perf_flush_cnt` (32, `branch_flag` cycles).
  - Both counters reset to 0 and wrap at 2^32.
- Without the macro, these ports and counters do not exist. Behaviour is otherwise identical.

## Test plan
- Reset release, `rom_ready=1`, 1-cycle memory returning `addr` as data, no stalls -> `rom_addr` 32'hBFC00000, …04, …08 on consecutive cycles. `inst_valid` first high 2 cycles after the first request, then every cycle with `inst==addr`.
- `stall_request` high for 5 cycles during a stream -> `rom_en` drops once 2 credits are used, the head is held stable, no word is lost or duplicated, and the stream resumes in order.
- `branch_flag` with `branch_addr=32'h8000_1003` while 2 requests are outstanding -> both responses dropped, next `rom_addr=32'h8000_1000`, first delivered `addr=32'h8000_1000`.
- `branch_flag` coinciding with `rom_rvalid` and with `stall_request=1` -> the response is discarded, the head is not popped, FIFO empty next cycle.
- `rom_ready` low for 3 cycles -> `rom_addr` held constant and `pc` not advanced. Assert `rst` low mid-stream -> all outputs return to reset values the next cycle.
- With `IF_PERF_CNT_EN`: deliver 10 instructions and 2 branches -> `perf_fetch_cnt=10`, `perf_flush_cnt=2`.
